// File: rtl/decode_n_seq.sv
// ---------------------------------------------------------------------------
// decode_n_seq
//
// Registered N-to-2**N one-hot decoder with enable, plus a scan mode in which
// the active line walks through all 2**N outputs, advancing once every DIV
// enabled clocks. Drives select/strobe lines for row/column drivers and
// multiplexed peripherals. With N=2 and scan unused it behaves as a 2x4
// decoder delayed by one clock.
//
// Parameters:
//   N    select width; output width is 2**N (N >= 1)
//   DIV  scan-mode clocks per step (DIV >= 1)
//
// Ports:
//   clk   in   1     rising-edge clock
//   rst   in   1     asynchronous, active-high reset
//   En    in   1     enable; low forces Y to zero and freezes idx/prescaler
//   mode  in   1     0 = direct decode, 1 = scan
//   load  in   1     capture I into the index register (while enabled)
//   I     in   N     select value
//   Y     out  2**N  registered one-hot output (or all zeros)
//   idx   out  N     current index register
//   wrap  out  1     one-clock pulse when scan steps from 2**N-1 to 0
// ---------------------------------------------------------------------------
module decode_n_seq #(
    parameter int unsigned N   = 2,
    parameter int unsigned DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                En,
    input  logic                mode,
    input  logic                load,
    input  logic [N-1:0]        I,
    output logic [(2**N)-1:0]   Y,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    localparam int unsigned W  = 2 ** N;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [N-1:0]  r_idx;
    logic [PW-1:0] r_presc;
    logic          r_mode_q;
    logic [W-1:0]  r_y;
    logic          r_wrap;

    logic [N-1:0]  w_idx_d;
    logic [PW-1:0] w_presc_d;
    logic          w_mode_d;
    logic [W-1:0]  w_y_d;
    logic          w_wrap_d;
    logic [W-1:0]  w_one;

    assign w_one = {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        w_idx_d   = r_idx;
        w_presc_d = r_presc;
        w_mode_d  = r_mode_q;
        w_wrap_d  = 1'b0;

        if (En) begin
            w_mode_d = mode;
            if (!mode) begin
                // Direct decode: prescaler parked at zero.
                w_presc_d = '0;
                if (load) begin
                    w_idx_d = I;
                end
            end else if (load) begin
                // Load beats stepping and restarts the scan period.
                w_idx_d   = I;
                w_presc_d = '0;
            end else if (mode != r_mode_q) begin
                // Entering scan: keep idx, start a full DIV period.
                w_presc_d = '0;
            end else if (r_presc == PRESC_LAST) begin
                w_presc_d = '0;
                w_idx_d   = r_idx + 1'b1;
                w_wrap_d  = (r_idx == '1);
            end else begin
                w_presc_d = r_presc + 1'b1;
            end
        end

        // Y tracks the next index so Y == (1 << idx) holds in the same cycle.
        w_y_d = En ? (w_one << w_idx_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_presc  <= '0;
            r_mode_q <= 1'b0;
            r_y      <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_idx    <= w_idx_d;
            r_presc  <= w_presc_d;
            r_mode_q <= w_mode_d;
            r_y      <= w_y_d;
            r_wrap   <= w_wrap_d;
        end
    end

    assign Y    = r_y;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_decode_n_seq.sv
// ---------------------------------------------------------------------------
// tb_decode_n_seq
//
// Directed self-checking bench. Instance u_a is N=2, DIV=3; instance u_b is
// N=3, DIV=1. Inputs are driven 1 time unit after each rising edge and the
// outputs are checked at that same point, i.e. after the edge has updated
// them.
// ---------------------------------------------------------------------------
module tb_decode_n_seq;

    logic       clk;
    logic       rst;

    logic       a_en, a_mode, a_load;
    logic [1:0] a_i;
    logic [3:0] a_y;
    logic [1:0] a_idx;
    logic       a_wrap;

    logic       b_en, b_mode, b_load;
    logic [2:0] b_i;
    logic [7:0] b_y;
    logic [2:0] b_idx;
    logic       b_wrap;

    int n_checks;
    int n_errors;

    decode_n_seq #(
        .N   (2),
        .DIV (3)
    ) u_a (
        .clk  (clk),
        .rst  (rst),
        .En   (a_en),
        .mode (a_mode),
        .load (a_load),
        .I    (a_i),
        .Y    (a_y),
        .idx  (a_idx),
        .wrap (a_wrap)
    );

    decode_n_seq #(
        .N   (3),
        .DIV (1)
    ) u_b (
        .clk  (clk),
        .rst  (rst),
        .En   (b_en),
        .mode (b_mode),
        .load (b_load),
        .I    (b_i),
        .Y    (b_y),
        .idx  (b_idx),
        .wrap (b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps;
        n_checks = 0;
        n_errors = 0;

        rst    = 1'b1;
        a_en   = 1'b0; a_mode = 1'b0; a_load = 1'b0; a_i = 2'd0;
        b_en   = 1'b0; b_mode = 1'b0; b_load = 1'b0; b_i = 3'd0;
        #12;
        check_val("rst_y",    32'(a_y),    32'h0);
        check_val("rst_idx",  32'(a_idx),  32'h0);
        check_val("rst_wrap", 32'(a_wrap), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1. Direct decode of I=0..3, one clock latency.
        a_en = 1'b1; a_load = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_i = 2'(k);
            #1;
            if (k > 0) check_val("t1_latency", 32'(a_y), 32'h1 << (k - 1));
            tick();
            check_val("t1_y",   32'(a_y),   32'h1 << k);
            check_val("t1_idx", 32'(a_idx), 32'(k));
        end

        // 2. En low for two clocks (load ignored), then the prior one-hot returns.
        a_en = 1'b0; a_load = 1'b1; a_i = 2'd1;
        tick();
        check_val("t2_off_y0",  32'(a_y),   32'h0);
        check_val("t2_off_idx", 32'(a_idx), 32'h3);
        tick();
        check_val("t2_off_y1",  32'(a_y),   32'h0);
        a_en = 1'b1; a_load = 1'b0;
        tick();
        check_val("t2_on_y",    32'(a_y),   32'h8);
        check_val("t2_on_idx",  32'(a_idx), 32'h3);

        // 3. Scan from idx 0, one step per 3 clocks, wrap on return to line 0.
        a_load = 1'b1; a_i = 2'd0;
        tick();
        check_val("t3_load0", 32'(a_y), 32'h1);
        a_load = 1'b0; a_mode = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check_val("t3_y",    32'(a_y),    32'h1 << (((k - 1) / 3) % 4));
            check_val("t3_wrap", 32'(a_wrap), (k == 13) ? 32'h1 : 32'h0);
        end

        // 4. Mid-period load of I=2, next step a full 3 clocks later.
        a_load = 1'b1; a_i = 2'd2;
        tick();
        check_val("t4_load_y",    32'(a_y),    32'h4);
        check_val("t4_load_wrap", 32'(a_wrap), 32'h0);
        a_load = 1'b0;
        tick();
        check_val("t4_hold1", 32'(a_y), 32'h4);
        tick();
        check_val("t4_hold2", 32'(a_y), 32'h4);
        tick();
        check_val("t4_step",  32'(a_y), 32'h8);

        // 5. Async reset between edges mid-scan.
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_rst_y",    32'(a_y),    32'h0);
        check_val("t5_rst_idx",  32'(a_idx),  32'h0);
        check_val("t5_rst_wrap", 32'(a_wrap), 32'h0);
        a_mode = 1'b0; a_load = 1'b1; a_i = 2'd3;
        tick();
        check_val("t5_rst_held", 32'(a_y), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_val("t5_after_y",   32'(a_y),   32'h8);
        check_val("t5_after_idx", 32'(a_idx), 32'h3);

        // 6. N=3, DIV=1 scan: one step per clock, wrap once per 8 clocks.
        a_en = 1'b0;
        b_en = 1'b1; b_mode = 1'b1; b_load = 1'b0;
        tick();
        check_val("t6_first_y", 32'(b_y), 32'h1);
        wraps = 0;
        for (int k = 2; k <= 17; k++) begin
            tick();
            check_val("t6_y",      32'(b_y),   32'h1 << ((k - 1) % 8));
            check_val("t6_idx",    32'(b_idx), 32'((k - 1) % 8));
            check_val("t6_onehot", ($countones(b_y) <= 1) ? 32'h1 : 32'h0, 32'h1);
            check_val("t6_wrap",   32'(b_wrap), (k == 9 || k == 17) ? 32'h1 : 32'h0);
            if (b_wrap) wraps++;
        end
        check_val("t6_wrap_count", 32'(wraps), 32'h2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
